// File: rtl/pe_mac_array.sv
// pe_mac_array: multi-lane multiply-accumulate processing element.
//
// Each accepted beat multiplies LANES pixel/weight pairs and sums them into
// one lane-sum. Mode 0 emits one lane-sum per beat. Mode 1 accumulates
// lane-sums until a beat flagged last, then emits the total. The pipeline is
// three stages deep: input registers, lane-sum register, output stage.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid/in_ready          input beat handshake
//   in_pixel, in_weight        LANES packed lanes, lane i at [i*W +: W]
//   in_mode, in_last           0 = per-beat sum, 1 = accumulate; last closes
//   pixel_out/pixel_out_valid  pixel forwarding to the neighbouring PE
//   out_valid/out_ready        result handshake
//   out_data                   result
//   err                        sticky protocol error (mode-0 beat while open)
//   sat                        sticky saturation flag
//
// Optional feature: define PE_MAC_SAT_EN to clamp a carrying accumulator
// addition to all-ones and set sat. Without it arithmetic wraps and sat is 0.
module pe_mac_array #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_pixel,
  input  logic [LANES*WEIGHT_WIDTH-1:0] in_weight,
  input  logic                          in_mode,
  input  logic                          in_last,
  output logic [LANES*DATA_WIDTH-1:0]   pixel_out,
  output logic                          pixel_out_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic                          err,
  output logic                          sat
);

  localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);

  logic stall;
  logic accept;

  // Stage 1: captured beat
  logic                          s1_valid_q,  s1_valid_d;
  logic [LANES*DATA_WIDTH-1:0]   s1_pixel_q,  s1_pixel_d;
  logic [LANES*WEIGHT_WIDTH-1:0] s1_weight_q, s1_weight_d;
  logic                          s1_mode_q,   s1_mode_d;
  logic                          s1_last_q,   s1_last_d;

  // Stage 2: lane-sum
  logic                          s2_valid_q,  s2_valid_d;
  logic [SUM_W-1:0]              s2_sum_q,    s2_sum_d;
  logic                          s2_mode_q,   s2_mode_d;
  logic                          s2_last_q,   s2_last_d;

  // Output stage and accumulator
  logic                          out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]          out_data_q,  out_data_d;
  logic [ACC_WIDTH-1:0]          acc_q,       acc_d;
  logic                          open_q,      open_d;
  logic                          err_q,       err_d;

  // Pixel forwarding
  logic [LANES*DATA_WIDTH-1:0]   pix_out_q,   pix_out_d;
  logic                          pix_vld_q,   pix_vld_d;

  logic [PROD_W-1:0]             prod [LANES];
  logic [SUM_W-1:0]              lane_sum;
  logic [ACC_WIDTH-1:0]          acc_base;
  logic [ACC_WIDTH-1:0]          acc_next;

`ifdef PE_MAC_SAT_EN
  logic                          sat_q, sat_d;
  logic [ACC_WIDTH:0]            acc_wide;
`endif

  assign stall  = out_valid_q & ~out_ready;
  assign accept = in_valid & ~stall;

  // One independent multiplier per lane, then an adder tree over the lanes.
  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i]  = PROD_W'(s1_pixel_q[i*DATA_WIDTH +: DATA_WIDTH]) *
                 PROD_W'(s1_weight_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      lane_sum = lane_sum + SUM_W'(prod[i]);
    end
  end

  // Accumulator adder; a closed accumulation restarts from zero.
  always_comb begin
    acc_base = open_q ? acc_q : '0;
`ifdef PE_MAC_SAT_EN
    acc_wide = {1'b0, acc_base} + (ACC_WIDTH+1)'(s2_sum_q);
    acc_next = acc_wide[ACC_WIDTH] ? '1 : acc_wide[ACC_WIDTH-1:0];
`else
    acc_next = acc_base + ACC_WIDTH'(s2_sum_q);
`endif
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_pixel_d  = s1_pixel_q;
    s1_weight_d = s1_weight_q;
    s1_mode_d   = s1_mode_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_sum_d    = s2_sum_q;
    s2_mode_d   = s2_mode_q;
    s2_last_d   = s2_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_d       = acc_q;
    open_d      = open_q;
    err_d       = err_q;
    pix_out_d   = pix_out_q;
    pix_vld_d   = accept;
`ifdef PE_MAC_SAT_EN
    sat_d       = sat_q;
`endif

    if (accept) begin
      pix_out_d = in_pixel;
    end

    // Without a stall, any result currently held is being consumed this edge,
    // so out_valid falls unless the output stage loads a new result.
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_pixel_d  = in_pixel;
        s1_weight_d = in_weight;
        s1_mode_d   = in_mode;
        s1_last_d   = in_last;
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_d  = lane_sum;
        s2_mode_d = s1_mode_q;
        s2_last_d = s1_last_q;
      end

      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (!s2_mode_q) begin
          out_data_d  = ACC_WIDTH'(s2_sum_q);
          out_valid_d = 1'b1;
          if (open_q) begin
            err_d  = 1'b1;
            open_d = 1'b0;
          end
        end else begin
`ifdef PE_MAC_SAT_EN
          if (acc_wide[ACC_WIDTH]) begin
            sat_d = 1'b1;
          end
`endif
          if (s2_last_q) begin
            out_data_d  = acc_next;
            out_valid_d = 1'b1;
            open_d      = 1'b0;
          end else begin
            acc_d  = acc_next;
            open_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_pixel_q  <= '0;
      s1_weight_q <= '0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_mode_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
      open_q      <= 1'b0;
      err_q       <= 1'b0;
      pix_out_q   <= '0;
      pix_vld_q   <= 1'b0;
`ifdef PE_MAC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_pixel_q  <= s1_pixel_d;
      s1_weight_q <= s1_weight_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_sum_q    <= s2_sum_d;
      s2_mode_q   <= s2_mode_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      acc_q       <= acc_d;
      open_q      <= open_d;
      err_q       <= err_d;
      pix_out_q   <= pix_out_d;
      pix_vld_q   <= pix_vld_d;
`ifdef PE_MAC_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign in_ready        = ~stall;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign err             = err_q;
  assign pixel_out       = pix_out_q;
  assign pixel_out_valid = pix_vld_q;
`ifdef PE_MAC_SAT_EN
  assign sat             = sat_q;
`else
  assign sat             = 1'b0;
`endif

endmodule

// File: tb/tb_pe_mac_array.sv
module tb_pe_mac_array;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 8;
  localparam int unsigned AW    = 20;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_pixel;
  logic [LANES*WW-1:0]   in_weight;
  logic                  in_mode;
  logic                  in_last;
  logic [LANES*DW-1:0]   pixel_out;
  logic                  pixel_out_valid;
  logic                  out_valid;
  logic                  out_ready;
  logic [AW-1:0]         out_data;
  logic                  err;
  logic                  sat;

  pe_mac_array #(
    .LANES       (LANES),
    .DATA_WIDTH  (DW),
    .WEIGHT_WIDTH(WW),
    .ACC_WIDTH   (AW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pixel       (in_pixel),
    .in_weight      (in_weight),
    .in_mode        (in_mode),
    .in_last        (in_last),
    .pixel_out      (pixel_out),
    .pixel_out_valid(pixel_out_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .err            (err),
    .sat            (sat)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: expected results in order, plus accumulation state.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  longint        m_acc  = 0;
  logic          m_open = 1'b0;
  logic          m_err  = 1'b0;
  logic          m_sat  = 1'b0;

`ifdef PE_MAC_SAT_EN
  localparam logic SAT_BUILD = 1'b1;
`else
  localparam logic SAT_BUILD = 1'b0;
`endif

  function automatic logic [LANES*DW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [LANES*DW-1:0] r;
    r = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return r;
  endfunction

  function automatic longint dot(input logic [LANES*DW-1:0] p, input logic [LANES*WW-1:0] w);
    longint s = 0;
    for (int i = 0; i < int'(LANES); i++)
      s += longint'(p[i*DW +: DW]) * longint'(w[i*WW +: WW]);
    return s;
  endfunction

  function automatic void model_beat(input logic md, input logic lst, input longint s);
    longint t;
    longint lim = longint'(1) << AW;
    if (!md) begin
      if (m_open) begin
        m_err  = 1'b1;
        m_open = 1'b0;
      end
      exp_q.push_back(s[AW-1:0]);
    end else begin
      t = (m_open ? m_acc : 0) + s;
      if (t >= lim) begin
        if (SAT_BUILD) begin
          t = lim - 1;
          m_sat = 1'b1;
        end else begin
          t = t - lim;
        end
      end
      if (lst) begin
        exp_q.push_back(t[AW-1:0]);
        m_open = 1'b0;
      end else begin
        m_acc  = t;
        m_open = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    m_acc  = 0;
    m_open = 1'b0;
    m_err  = 1'b0;
    m_sat  = 1'b0;
    exp_q.delete();
    got_q.delete();
  endfunction

  // Drives one cycle at the falling edge and reports what the next rising
  // edge will do: beat acceptance and result handshake.
  task automatic step(input logic v, input logic md, input logic lst,
                      input logic [LANES*DW-1:0] px, input logic [LANES*WW-1:0] wt,
                      input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_mode   = md;
    in_last   = lst;
    in_pixel  = px;
    in_weight = wt;
    out_ready = ordy;
    #1;
    acc = in_valid & in_ready;
    if (out_valid & out_ready) got_q.push_back(out_data);
    if (acc) model_beat(md, lst, dot(px, wt));
  endtask

  task automatic drain();
    logic a;
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic test_reset();
    in_valid = 0; in_mode = 0; in_last = 0; in_pixel = '0; in_weight = '0; out_ready = 1;
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_data, pixel_out, pixel_out_valid, err, sat} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ov=%0b od=%0d po=%h pov=%0b err=%0b sat=%0b required all 0",
               out_valid, out_data, pixel_out, pixel_out_valid, err, sat);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_mode0();
    logic a;
    logic [LANES*DW-1:0] p = pack(1, 2, 3, 4);
    logic [LANES*WW-1:0] w = pack(5, 6, 7, 8);
    step(1'b1, 1'b0, 1'b0, p, w, 1'b1, a);
    n_vec++;
    if (a !== 1'b1) begin n_err++; $display("FAIL mode0_accept: got %0b required 1", a); end
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a);
    n_vec++;
    if (pixel_out_valid !== 1'b1 || pixel_out !== p) begin
      n_err++;
      $display("FAIL mode0_fwd: got pov=%0b po=%h required pov=1 po=%h", pixel_out_valid, pixel_out, p);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a);
    n_vec++;
    if (pixel_out_valid !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mode0_e1: got pov=%0b ov=%0b required 0 0", pixel_out_valid, out_valid);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 20'd70) begin
      n_err++;
      $display("FAIL mode0_result: got ov=%0b od=%0d required ov=1 od=70", out_valid, out_data);
    end
    drain();
    n_vec++;
    if (got_q.size() != 1) begin
      n_err++;
      $display("FAIL mode0_count: got %0d results required 1", got_q.size());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_accumulate();
    logic a;
    logic [LANES*DW-1:0] p = pack(255, 255, 255, 255);
    for (int b = 0; b < 3; b++) step(1'b1, 1'b1, (b == 2), p, p, 1'b1, a);
    drain();
    n_vec++;
    if (got_q.size() != 1) begin
      n_err++;
      $display("FAIL acc_count: got %0d results required 1", got_q.size());
    end else begin
      n_vec++;
      if (got_q[0] !== 20'd780300) begin
        n_err++;
        $display("FAIL acc_value: got %0d required 780300", got_q[0]);
      end
    end
    n_vec++;
    if (sat !== 1'b0) begin n_err++; $display("FAIL acc_sat: got %0b required 0", sat); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic a;
    int   sent = 0;
    int   stalls = 0;
    for (int c = 0; c < 40 && sent < 4; c++) begin
      step(1'b1, 1'b0, 1'b0, pack(10 * (sent + 1), 0, 0, 0), pack(1, 0, 0, 0), (c >= 5), a);
      if (out_valid && !out_ready) begin
        stalls++;
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_in_ready: got %0b required 0 during stall", in_ready);
        end
      end
      if (a) sent++;
    end
    drain();
    n_vec++;
    if (stalls == 0 || got_q.size() != 4) begin
      n_err++;
      $display("FAIL bp_count: got %0d results, %0d stall cycles; required 4 results and >0 stalls",
               got_q.size(), stalls);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got_q[i] !== AW'(10 * (i + 1))) begin
          n_err++;
          $display("FAIL bp_order[%0d]: got %0d required %0d", i, got_q[i], 10 * (i + 1));
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic a;
    logic [LANES*DW-1:0] p = pack(255, 255, 255, 255);
    logic [AW-1:0] want = SAT_BUILD ? 20'd1048575 : 20'd251924;
    for (int b = 0; b < 5; b++) step(1'b1, 1'b1, (b == 4), p, p, 1'b1, a);
    drain();
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      n_err++;
      $display("FAIL ovf_value: got %0d results first=%0d required 1 result %0d",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 0, want);
    end
    n_vec++;
    if (sat !== SAT_BUILD) begin
      n_err++;
      $display("FAIL ovf_sat: got %0b required %0b", sat, SAT_BUILD);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_protocol_err();
    logic a;
    step(1'b1, 1'b1, 1'b0, pack(50, 0, 0, 0), pack(1, 0, 0, 0), 1'b1, a);
    step(1'b1, 1'b0, 1'b1, pack(7, 0, 0, 0),  pack(1, 0, 0, 0), 1'b1, a);
    step(1'b1, 1'b1, 1'b1, pack(9, 0, 0, 0),  pack(1, 0, 0, 0), 1'b1, a);
    drain();
    n_vec++;
    if (got_q.size() != 2 || got_q[0] !== 20'd7 || got_q[1] !== 20'd9) begin
      n_err++;
      $display("FAIL perr_values: got %0d results [%0d,%0d] required [7,9]", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 0, (got_q.size() > 1) ? got_q[1] : 0);
    end
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL perr_flag: got %0b required 1", err); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic a;
    step(1'b1, 1'b1, 1'b0, pack(9, 9, 9, 9), pack(9, 9, 9, 9), 1'b0, a);
    step(1'b1, 1'b1, 1'b0, pack(9, 9, 9, 9), pack(9, 9, 9, 9), 1'b0, a);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, a);
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_data, pixel_out, pixel_out_valid, err, sat} !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid: got ov=%0b od=%0d pov=%0b err=%0b sat=%0b rdy=%0b required zeros, rdy=1",
               out_valid, out_data, pixel_out_valid, err, sat, in_ready);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b1, 1'b1, pack(2, 0, 0, 0), pack(3, 0, 0, 0), 1'b1, a);
    drain();
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== 20'd6) begin
      n_err++;
      $display("FAIL rst_clean_acc: got %0d results first=%0d required 1 result 6",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 0);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic a;
    logic pend = 1'b0;
    logic md = 1'b0, lst = 1'b0;
    logic [LANES*DW-1:0] px = '0;
    logic [LANES*WW-1:0] wt = '0;
    logic prev_acc = 1'b0;
    logic [LANES*DW-1:0] prev_px = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        px   = $urandom;
        wt   = $urandom;
        md   = ($urandom_range(0, 5) != 0);
        lst  = ($urandom_range(0, 2) == 0);
      end
      step(pend, md, lst, px, wt, ($urandom_range(0, 3) != 0), a);
      n_vec++;
      if (pixel_out_valid !== prev_acc || (prev_acc && pixel_out !== prev_px)) begin
        n_err++;
        $display("FAIL rnd_fwd[%0d]: got pov=%0b po=%h required pov=%0b po=%h",
                 c, pixel_out_valid, pixel_out, prev_acc, prev_px);
      end
      prev_acc = a;
      if (a) begin
        prev_px = px;
        pend    = 1'b0;
      end
    end
    drain();
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rnd_count: got %0d results required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL rnd_result[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_vec++;
    if (err !== m_err || sat !== m_sat) begin
      n_err++;
      $display("FAIL rnd_flags: got err=%0b sat=%0b required err=%0b sat=%0b", err, sat, m_err, m_sat);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_accumulate();
    test_back_to_back();
    test_overflow();
    test_protocol_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_mac_array.md
Name: pe_mac_array

Overview:
- Parametrised multiply-accumulate processing element; successor of the single-lane PE.
- Each accepted beat multiplies LANES pixel/weight pairs and sums them into one lane-sum.
- Mode 0 emits one lane-sum per beat. Mode 1 accumulates lane-sums until a beat flagged last, then emits the total.
- Sits in the convolution array: it forwards pixels to the neighbouring PE and uses valid/ready handshakes on both sides.

Parameters:
- LANES, 4, number of parallel pixel/weight pairs per beat (>=1).
- DATA_WIDTH, 8, pixel width per lane (unsigned).
- WEIGHT_WIDTH, 8, weight width per lane (unsigned).
- ACC_WIDTH, 32, accumulator/result width; must be >= DATA_WIDTH+WEIGHT_WIDTH+clog2(LANES).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock, asynchronous assert, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_pixel  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_weight  in  LANES*WEIGHT_WIDTH  lane i likewise
- in_mode  in  1  0 = per-beat product sum, 1 = accumulate
- in_last  in  1  closes accumulation (mode 1 only)
- pixel_out  out  LANES*DATA_WIDTH  copy of last accepted in_pixel
- pixel_out_valid  out  1  one-cycle pulse after each accepted beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_WIDTH  result
- err  out  1  sticky protocol error
- sat  out  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset values: all outputs 0 except in_ready=1; pipeline valid bits, accumulator and open-accumulation flag cleared. Reset mid-accumulation discards the partial sum.
- Accept: a beat is accepted when in_valid & in_ready at a rising edge.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall. While stalled, every stage (including the accumulator) holds.
- Latency:
  - Edge E0 (accept): S1 registers pixel, weight, mode, last.
  - E1: S2 registers lane-sum = sum over lanes of pixel*weight. Width is DATA_WIDTH+WEIGHT_WIDTH+clog2(LANES), zero-extended to ACC_WIDTH.
  - E2: output stage updates.
  - Full throughput of 1 beat/cycle without backpressure.
- Mode 0 beat at output stage:
  - out_data = lane-sum; out_valid = 1. in_last is ignored.
  - If an accumulation is open, its partial sum is discarded, the open flag is cleared and err is set.
- Mode 1 beat at output stage:
  - acc_next = (open ? acc : 0) + lane-sum.
  - last = 0: acc <= acc_next, open <= 1, out_valid not raised.
  - last = 1: out_data <= acc_next, out_valid = 1, open <= 0.
- Output handshake:
  - out_valid clears on out_valid & out_ready unless a new result is loaded on the same edge.
  - out_data holds while out_valid & ~out_ready.
- Accumulator arithmetic: unsigned, wraps modulo 2^ACC_WIDTH (without macro).
- Pixel forwarding:
  - pixel_out <= in_pixel on each accepted beat, with pixel_out_valid = 1 the following cycle, else 0.
  - Forwarding is independent of the result pipeline; no stall coupling beyond acceptance.
- err: sticky until reset.
- Multipliers: implement as per-lane DSP multipliers.

Optional Feature:
- Macro PE_MAC_SAT_EN.
- Defined: any ACC_WIDTH-bit addition that carries out clamps to 2^ACC_WIDTH-1, and sat is set (sticky until reset). Once saturated, the accumulation stays clamped until closed.
- Undefined: arithmetic wraps and sat is tied to 0.

Test Plan:
- Reset: assert rstn=0 mid-stream -> all outputs 0 and in_ready=1 immediately (async). After release, a new mode-1 sequence is not contaminated by the old partial sum.
- Mode 0, LANES=4: pixels {1,2,3,4}, weights {5,6,7,8} accepted at E0 -> out_valid=1 with out_data=70 after E2; pixel_out={1,2,3,4} with pixel_out_valid pulsing after E0.
- Mode 1: three beats, all lanes 255*255, in_last on the third -> exactly one out_valid, out_data=780300; no out_valid for the first two beats.
- Backpressure: stream 4 mode-0 beats with sums 10,20,30,40 while out_ready=0 for 5 cycles -> in_ready drops when out_valid=1. After out_ready=1, results are 10,20,30,40 in order with none lost or duplicated.
- Overflow, ACC_WIDTH=20, mode 1: 5 beats of 260100 (last on 5th) -> without macro out_data=251924, sat=0; with PE_MAC_SAT_EN out_data=1048575, sat=1.
- Protocol error: mode-1 beat sum 50 (last=0) then mode-0 beat sum 7 -> out_data=7 and err=1. A following mode-1 beat 9 with last=1 -> out_data=9.
